// File: rtl/hls_fp16_to_fp32_pkg.sv
// hls_fp16_to_fp32_pkg: shared types and widths for the fp16_to_fp32 output channel
package hls_fp16_to_fp32_pkg;
  localparam int CHN_O_DATA_W = 32;
  localparam int STALL_CNT_W  = 16;
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} skid_state_e;
endpackage

// File: rtl/hls_fp16_to_fp32_sat_cnt.sv
// hls_fp16_to_fp32_sat_cnt: saturating up-counter with synchronous clear (clear wins)
module hls_fp16_to_fp32_sat_cnt #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
  assign o_cnt = r_cnt;
endmodule

// File: rtl/hls_fp16_to_fp32_chn_o_skid.sv
// hls_fp16_to_fp32_chn_o_skid: two-entry registered skid buffer on the core output channel.
// Optional stall counter enabled by HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN.
module hls_fp16_to_fp32_chn_o_skid
  import hls_fp16_to_fp32_pkg::*;
#(
  parameter int DATA_W = CHN_O_DATA_W
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              chn_o_core_vld,
  input  logic [DATA_W-1:0] chn_o_core_dat,
  output logic              chn_o_core_rdy,
  output logic              chn_o_vld,
  output logic [DATA_W-1:0] chn_o_dat,
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
  input  logic                   chn_o_stall_cnt_clr,
  output logic [STALL_CNT_W-1:0] chn_o_stall_cnt,
`endif
  input  logic              chn_o_rdy
);
  skid_state_e       r_state, w_next_state;
  logic [DATA_W-1:0] r_main, r_skid;
  logic              r_core_rdy;
  logic              w_push, w_pop, w_main_ld_din, w_main_ld_skid, w_skid_ld;

  assign w_push = chn_o_core_vld & r_core_rdy;
  assign w_pop  = chn_o_vld & chn_o_rdy;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) r_state <= EMPTY;
    else r_state <= w_next_state;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY:   w_next_state = w_push ? HALF : EMPTY;
      HALF:    w_next_state = (w_push && !w_pop) ? FULL : (!w_push && w_pop) ? EMPTY : HALF;
      FULL:    w_next_state = w_pop ? HALF : FULL;
      default: w_next_state = EMPTY;
    endcase
  end

  // Push never happens in FULL (rdy is low) and pop never in EMPTY (vld is low).
  always_comb begin
    w_main_ld_din  = w_push && (r_state == EMPTY || (r_state == HALF && w_pop));
    w_main_ld_skid = (r_state == FULL) && w_pop;
    w_skid_ld      = (r_state == HALF) && w_push && !w_pop;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_core_rdy <= 1'b0;
    end else begin
      r_core_rdy <= (w_next_state != FULL);
      if (w_main_ld_din) r_main <= chn_o_core_dat;
      else if (w_main_ld_skid) r_main <= r_skid;
      if (w_skid_ld) r_skid <= chn_o_core_dat;
    end

  assign chn_o_vld      = (r_state != EMPTY);
  assign chn_o_dat      = r_main;
  assign chn_o_core_rdy = r_core_rdy;

`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
  hls_fp16_to_fp32_sat_cnt #(.W(STALL_CNT_W)) u_stall_cnt (
    .i_clk   (nvdla_core_clk),
    .i_rst_n (nvdla_core_rstn),
    .i_inc   (chn_o_vld & ~chn_o_rdy),
    .i_clr   (chn_o_stall_cnt_clr),
    .o_cnt   (chn_o_stall_cnt)
  );
`endif
endmodule

// File: tb/tb_hls_fp16_to_fp32_chn_o_skid.sv
// tb_hls_fp16_to_fp32_chn_o_skid: directed stimulus with a FIFO scoreboard on the consumer side
module tb_hls_fp16_to_fp32_chn_o_skid;
  logic        clk = 1'b0, rstn = 1'b0, core_vld = 1'b0, o_rdy = 1'b0;
  logic [31:0] core_dat = '0;
  logic        core_rdy, vld;
  logic [31:0] dat;
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
  logic        clr = 1'b0;
  logic [15:0] cnt;
`endif
  int          tests = 0, fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  hls_fp16_to_fp32_chn_o_skid dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .chn_o_core_vld  (core_vld),
    .chn_o_core_dat  (core_dat),
    .chn_o_core_rdy  (core_rdy),
    .chn_o_vld       (vld),
    .chn_o_dat       (dat),
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
    .chn_o_stall_cnt_clr (clr),
    .chn_o_stall_cnt     (cnt),
`endif
    .chn_o_rdy       (o_rdy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: record an accepted word as expected output, then advance past the edge.
  task automatic cyc();
    @(negedge clk);
    if (rstn && core_vld && core_rdy) exp_q.push_back(core_dat);
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (rstn && vld && o_rdy) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_word: got %h expected none", dat);
      end else chk("scoreboard", dat, exp_q.pop_front());
    end
  end

  initial begin
    core_vld = 1'b1;
    core_dat = 32'h3F800000;
    @(negedge clk);
    chk("rst_vld", {31'd0, vld}, 32'd0);
    chk("rst_core_rdy", {31'd0, core_rdy}, 32'd0);
    chk("rst_dat", dat, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    chk("rdy_cycle0", {31'd0, core_rdy}, 32'd0);
    @(posedge clk); #1;
    chk("rdy_cycle1", {31'd0, core_rdy}, 32'd1);
    cyc();
    chk("first_vld", {31'd0, vld}, 32'd1);
    chk("first_dat", dat, 32'h3F800000);
    core_vld = 1'b0;
    o_rdy = 1'b1;
    cyc();
    chk("first_drain", {31'd0, vld}, 32'd0);
    // streaming at full rate
    core_vld = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      core_dat = i;
      chk("stream_rdy", {31'd0, core_rdy}, 32'd1);
      cyc();
      chk("stream_dat", dat, i);
    end
    core_vld = 1'b0;
    cyc();
    chk("stream_drain", {31'd0, vld}, 32'd0);
    // backpressure with A, B, C
    o_rdy = 1'b0;
    core_vld = 1'b1;
    core_dat = 32'hAAAA0001;
    cyc();
    core_dat = 32'hBBBB0002;
    cyc();
    chk("bp_rdy_drop", {31'd0, core_rdy}, 32'd0);
    core_dat = 32'hCCCC0003;
    repeat (3) begin
      cyc();
      chk("bp_hold_dat", dat, 32'hAAAA0001);
      chk("bp_hold_rdy", {31'd0, core_rdy}, 32'd0);
    end
    o_rdy = 1'b1;
    cyc();
    chk("release_rdy", {31'd0, core_rdy}, 32'd1);
    chk("release_dat", dat, 32'hBBBB0002);
    cyc();
    chk("bp_c_dat", dat, 32'hCCCC0003);
    core_vld = 1'b0;
    cyc();
    chk("bp_drain", {31'd0, vld}, 32'd0);
    // simultaneous push and pop in HALF
    o_rdy = 1'b0;
    core_vld = 1'b1;
    core_dat = 32'd100;
    cyc();
    o_rdy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      core_dat = 32'd100 + i;
      cyc();
      chk("pp_dat", dat, 32'd100 + i);
      chk("pp_rdy", {31'd0, core_rdy}, 32'd1);
    end
    core_vld = 1'b0;
    cyc();
    chk("pp_drain", {31'd0, vld}, 32'd0);
    // async reset while FULL
    o_rdy = 1'b0;
    core_vld = 1'b1;
    core_dat = 32'h12345678;
    cyc();
    core_dat = 32'h9ABCDEF0;
    cyc();
    chk("full_rdy", {31'd0, core_rdy}, 32'd0);
    chk("full_vld", {31'd0, vld}, 32'd1);
    core_vld = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_vld", {31'd0, vld}, 32'd0);
    chk("arst_rdy", {31'd0, core_rdy}, 32'd0);
    chk("arst_dat", dat, 32'd0);
    exp_q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    o_rdy = 1'b1;
    repeat (4) begin
      cyc();
      chk("no_stale", {31'd0, vld}, 32'd0);
    end
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
    o_rdy = 1'b0;
    core_vld = 1'b1;
    core_dat = 32'h00000055;
    cyc();
    core_vld = 1'b0;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("cnt_clr0", {16'd0, cnt}, 32'd0);
    repeat (5) cyc();
    chk("cnt_five", {16'd0, cnt}, 32'd5);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("cnt_clr1", {16'd0, cnt}, 32'd0);
    repeat (65540) cyc();
    chk("cnt_sat", {16'd0, cnt}, 32'h0000FFFF);
    o_rdy = 1'b1;
    cyc();
    cyc();
`endif
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
